ripple_count_monitor: RTL

RIPPLE_COUNT_MONITOR -- requirements
Module: ripple_count_monitor

---
 rtl/ripple_mon_pkg.sv | 19 +
 rtl/sync2.sv | 24 ++
 rtl/ripple_count_monitor.sv | 111 +++++++++++
 3 files changed

// File: rtl/ripple_mon_pkg.sv
// Shared types and constants for the ripple counter monitor.
// The observed counter is 3 bits wide, so all step arithmetic is modulo 8.
package ripple_mon_pkg;

    localparam int CNT_W   = 3;
    localparam int CNT_MOD = 8;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    // Width truncation makes the subtraction wrap modulo CNT_MOD.
    function automatic logic [CNT_W-1:0] step_delta(input logic [CNT_W-1:0] next_val,
                                                    input logic [CNT_W-1:0] prev_val);
        return next_val - prev_val;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer; both stages are exposed so the consumer can tell
// whether the second stage is about to change on the next edge.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] s1,
    output logic [WIDTH-1:0] s2
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            // NOTE: non-blocking assignments give a true two-stage shift; blocking would collapse it to one flop.
            s1 <= d;
            s2 <= s1;
        end
    end

endmodule

// File: rtl/ripple_count_monitor.sv
// Debounces a glitchy asynchronous 3-bit up/down ripple counter and keeps a
// signed net step count, flagging illegal steps and direction/mode mismatches.
module ripple_count_monitor
    import ripple_mon_pkg::*;
#(
    parameter int STABLE_CYCLES = 3,
    parameter int ACC_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] q_in,
    input  logic             m_in,
    input  logic             clr,
    output logic             count_valid,
    output logic [CNT_W-1:0] count_val,
    output logic             dir,
    output logic             step_err,
    output logic             mode_err,
    output logic             locked,
    output logic [ACC_W-1:0] acc
);

    localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);

    logic [CNT_W:0]   s1_bus;
    logic [CNT_W:0]   s2_bus;
    logic [CNT_W-1:0] s2_q;
    logic             s2_m;
    logic             unused_s1_m;
    logic             q_hold;
    logic             accept;
    logic [CNT_W-1:0] delta;
    logic [STAB_W-1:0] stab_cnt;
    state_t           state;

    sync2 #(.WIDTH(CNT_W + 1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({m_in, q_in}),
        .s1    (s1_bus),
        .s2    (s2_bus)
    );

    assign s2_q        = s2_bus[CNT_W-1:0];
    assign s2_m        = s2_bus[CNT_W];
    assign unused_s1_m = s1_bus[CNT_W];

    // s2 keeps its value across the coming edge exactly when s1 already equals it.
    assign q_hold = (s1_bus[CNT_W-1:0] == s2_q);
    assign accept = q_hold && (stab_cnt == STAB_MAX) &&
                    ((s2_q != count_val) || (state == UNLOCKED));
    assign delta  = step_delta(s2_q, count_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt <= '0;
        end else if (!q_hold) begin
            stab_cnt <= '0;
        end else if (stab_cnt != STAB_MAX) begin
            stab_cnt <= stab_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= UNLOCKED;
            count_valid <= 1'b0;
            count_val   <= '0;
            dir         <= 1'b0;
            step_err    <= 1'b0;
            mode_err    <= 1'b0;
            locked      <= 1'b0;
            acc         <= '0;
        end else begin
            count_valid <= 1'b0;
            step_err    <= 1'b0;
            mode_err    <= 1'b0;
            // Clear has priority and silently drops an accept on the same edge.
            if (clr) begin
                state  <= UNLOCKED;
                locked <= 1'b0;
                acc    <= '0;
            end else if (accept) begin
                count_valid <= 1'b1;
                count_val   <= s2_q;
                unique case (state)
                    UNLOCKED: begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end
                    LOCKED: begin
                        if (delta == CNT_W'(1)) begin
                            dir      <= 1'b1;
                            acc      <= acc + ACC_W'(1);
                            mode_err <= !s2_m;
                        end else if (delta == CNT_W'(CNT_MOD - 1)) begin
                            dir      <= 1'b0;
                            acc      <= acc - ACC_W'(1);
                            mode_err <= s2_m;
                        end else begin
                            step_err <= 1'b1;
                        end
                    end
                    default: state <= UNLOCKED;
                endcase
            end
        end
    end

endmodule
